// File: rtl/sdpb_frame_reader_if.sv
// Valid/ready word stream from the frame reader to the matrix serializer.
interface sdpb_frame_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (output m_data, m_valid, m_last, input m_ready);
  modport slave  (input m_data, m_valid, m_last, output m_ready);
endinterface

// File: rtl/sdpb_frame_reader.sv
// Streams one bank of the double-buffered frame store out of the BRAM read port,
// with a 2-entry fall-through FIFO hiding the 1-cycle read latency.
module sdpb_frame_reader #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int FRAME_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  bank,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_ceb,
  output logic [ADDR_WIDTH-1:0] ram_adb,
  output logic                  ram_oce,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  sdpb_frame_reader_if.master   m
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE_S} state_t;

  state_t                     state;
  logic                       bank_q;
  logic [ADDR_WIDTH-1:0]      issue_cnt, out_cnt, adb_q;
  logic                       inflight;
  logic [1:0]                 cnt;
  logic                       wr_ptr, rd_ptr;
  logic [1:0][DATA_WIDTH-1:0] mem;

  logic                  pop, issue;
  logic [ADDR_WIDTH-1:0] base, rd_addr;

  assign pop = m.m_valid & m.m_ready;

  // Credit rule: FIFO words plus the read in flight, less this cycle's pop, must leave room.
  always_comb begin
    base    = bank_q ? ADDR_WIDTH'(FRAME_WORDS) : '0;
    rd_addr = base + issue_cnt;
    issue   = (state == READ) && !abort &&
              (({1'b0, cnt} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
  end

  assign ram_ceb   = issue;
  assign ram_adb   = issue ? rd_addr : adb_q;
  assign ram_oce   = 1'b1;
  assign busy      = (state == READ) || (state == DRAIN);
  assign done      = (state == DONE_S);
  assign m.m_valid = (cnt != 2'd0);
  assign m.m_data  = mem[rd_ptr];
  assign m.m_last  = m.m_valid && (out_cnt == ADDR_WIDTH'(FRAME_WORDS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bank_q    <= 1'b0;
      issue_cnt <= '0;
      out_cnt   <= '0;
      adb_q     <= '0;
      inflight  <= 1'b0;
      cnt       <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      mem       <= '0;
    end else begin
      if (issue) adb_q <= rd_addr;
      if (abort && state != IDLE) begin
        // Cancel drops the FIFO contents and whatever read is still in flight.
        state    <= IDLE;
        inflight <= 1'b0;
        cnt      <= '0;
        wr_ptr   <= 1'b0;
        rd_ptr   <= 1'b0;
      end else begin
        inflight <= issue;
        if (inflight) begin
          mem[wr_ptr] <= ram_dout;
          wr_ptr      <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr  <= ~rd_ptr;
          out_cnt <= out_cnt + 1'b1;
        end
        cnt <= cnt + {1'b0, inflight} - {1'b0, pop};
        if (issue) issue_cnt <= issue_cnt + 1'b1;
        case (state)
          IDLE, DONE_S: begin
            if (start && !abort) begin
              state     <= READ;
              bank_q    <= bank;
              issue_cnt <= '0;
              out_cnt   <= '0;
            end else begin
              state <= IDLE;
            end
          end
          READ:    if (issue && issue_cnt == ADDR_WIDTH'(FRAME_WORDS - 1)) state <= DRAIN;
          DRAIN:   if (pop && m.m_last) state <= DONE_S;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sdpb_frame_reader.sv
// Scoreboard bench for sdpb_frame_reader with an addr=data BRAM model.
module tb_sdpb_frame_reader;
  localparam int AW = 9, DW = 32, FW = 256;

  logic clk = 0, reset = 1, start = 0, bank = 0, abort = 0;
  logic busy, done, ram_ceb, ram_oce;
  logic [AW-1:0] ram_adb;
  logic [DW-1:0] ram_dout = '0;

  sdpb_frame_reader_if #(.DATA_WIDTH(DW)) sif ();

  sdpb_frame_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_WORDS(FW)) dut (
    .clk(clk), .reset(reset), .start(start), .bank(bank), .abort(abort),
    .busy(busy), .done(done), .ram_ceb(ram_ceb), .ram_adb(ram_adb),
    .ram_oce(ram_oce), .ram_dout(ram_dout), .m(sif)
  );

  always #5 clk = ~clk;

  // BRAM read port: data equals address, one-cycle latency
  always @(posedge clk) if (ram_ceb) ram_dout <= DW'(ram_adb);

  typedef struct { logic [DW-1:0] d; logic l; } exp_t;
  exp_t exp_q[$];

  int total = 0, bad = 0;
  int cyc = 0, c0 = 0;
  int issued = 0, hs = 0, busy_cnt = 0, done_cnt = 0;
  int first_vld = -1, last_cyc = -1, done_cyc = -1;
  int exp_addr = 0;
  logic          prev_stall = 0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: credit/address check on every read, scoreboard on every handshake
  always @(negedge clk) begin
    logic p;
    exp_t e;
    p = sif.m_valid && sif.m_ready;
    if (!reset) begin
      if (ram_ceb) begin
        chk("credit", DW'((issued - hs - (p ? 1 : 0)) < 2), 1);
        chk("adb", DW'(ram_adb), DW'(exp_addr));
        exp_addr++;
        issued++;
      end
      if (prev_stall) chk("stable", sif.m_data, prev_data);
      if (p) begin
        if (exp_q.size() == 0) chk("extra_word", sif.m_data, 32'hDEAD_BEEF);
        else begin
          e = exp_q.pop_front();
          chk("data", sif.m_data, e.d);
          chk("last", DW'(sif.m_last), DW'(e.l));
        end
        if (sif.m_last) last_cyc = cyc;
        hs++;
      end
      if (sif.m_valid && first_vld < 0) first_vld = cyc;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
    prev_stall = sif.m_valid && !sif.m_ready;
    prev_data  = sif.m_data;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start across edge E0; returns in cycle 1 of the new frame.
  task automatic start_frame(input logic b);
    exp_t e;
    for (int i = 0; i < FW; i++) begin
      e.d = DW'(b * FW + i);
      e.l = (i == FW - 1);
      exp_q.push_back(e);
    end
    exp_addr = b * FW; issued = 0; hs = 0; busy_cnt = 0;
    first_vld = -1; last_cyc = -1; done_cyc = -1;
    start = 1; bank = b;
    tick(1);
    c0 = cyc;
    start = 0;
  endtask

  task automatic wait_done(input int mode);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt != d0) break;
      if (mode == 1) sif.m_ready = ~sif.m_ready;
      tick(1);
    end
    chk("done_timeout", DW'(done_cnt != d0), 1);
    sif.m_ready = 1;
  endtask

  initial begin
    int d0, h0;
    sif.m_ready = 1;
    tick(2);
    chk("rst_busy", DW'(busy), 0);
    chk("rst_valid", DW'(sif.m_valid), 0);
    chk("rst_ceb", DW'(ram_ceb), 0);
    chk("rst_adb", DW'(ram_adb), 0);
    chk("rst_data", sif.m_data, 0);
    chk("oce", DW'(ram_oce), 1);
    reset = 0;
    tick(2);

    // Full-rate frame from bank 0
    start_frame(0);
    chk("c1_busy", DW'(busy), 1);
    chk("c1_ceb", DW'(ram_ceb), 1);
    wait_done(0);
    tick(2);
    chk("t1_first_vld", DW'(first_vld - c0), 2);
    chk("t1_last_cyc", DW'(last_cyc - c0), 257);
    chk("t1_done_cyc", DW'(done_cyc - c0), 258);
    chk("t1_busy_cnt", DW'(busy_cnt), 258);
    chk("t1_q_empty", DW'(exp_q.size()), 0);

    // Bank 1 with toggling backpressure
    start_frame(1);
    wait_done(1);
    tick(2);
    chk("t2_q_empty", DW'(exp_q.size()), 0);

    // Held off for 20 cycles: exactly two reads, then full rate on release
    sif.m_ready = 0;
    start_frame(0);
    tick(20);
    chk("t3_issued", DW'(issued), 2);
    chk("t3_valid", DW'(sif.m_valid), 1);
    chk("t3_head", sif.m_data, 0);
    h0 = hs;
    sif.m_ready = 1;
    tick(50);
    chk("t3_rate", DW'(hs - h0), 50);
    wait_done(0);
    tick(2);

    // Abort at cycle 50
    d0 = done_cnt;
    start_frame(0);
    tick(49);
    abort = 1;
    tick(1);
    abort = 0;
    exp_q.delete();
    chk("t4_busy", DW'(busy), 0);
    chk("t4_valid", DW'(sif.m_valid), 0);
    tick(5);
    chk("t4_no_done", DW'(done_cnt - d0), 0);
    abort = 1; start = 1;
    tick(1);
    abort = 0; start = 0;
    tick(1);
    chk("t4_abort_wins", DW'(busy), 0);
    start_frame(0);
    wait_done(0);
    tick(2);
    chk("t4_q_empty", DW'(exp_q.size()), 0);

    // Stray start mid-frame ignored; start in DONE cycle accepted
    start_frame(0);
    tick(99);
    start = 1; bank = 1;
    tick(1);
    start = 0;
    tick(158);
    chk("t5_done_now", DW'(done), 1);
    start_frame(1);
    wait_done(0);
    tick(2);
    chk("t5_first_vld", DW'(first_vld - c0), 2);
    chk("t5_q_empty", DW'(exp_q.size()), 0);

    // Async reset between edges mid-frame
    start_frame(0);
    tick(30);
    #2 reset = 1;
    #1;
    chk("t6_busy", DW'(busy), 0);
    chk("t6_valid", DW'(sif.m_valid), 0);
    chk("t6_ceb", DW'(ram_ceb), 0);
    chk("t6_adb", DW'(ram_adb), 0);
    chk("t6_data", sif.m_data, 0);
    chk("t6_last", DW'(sif.m_last), 0);
    tick(2);
    reset = 0;
    exp_q.delete();
    tick(3);
    chk("t6_empty", DW'(sif.m_valid), 0);
    start_frame(1);
    wait_done(0);
    tick(2);
    chk("t6_q_empty", DW'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdpb_frame_reader.md
Name: sdpb_frame_reader

Overview:
Read-side controller for the double-buffered frame store built on the 512x32 simple dual-port BRAM (port A write, port B read, bypass read mode, 1-cycle read latency). On a start pulse it streams one frame bank (FRAME_WORDS words) out of the BRAM's read port onto a valid/ready stream toward the matrix serializer. A 2-entry output FIFO absorbs the fixed read latency so downstream backpressure never loses data. The HDMI-side writer fills the opposite bank concurrently.

Parameters:
ADDR_WIDTH, 9, BRAM read address width (adb).
DATA_WIDTH, 32, BRAM word width.
FRAME_WORDS, 256, words per bank; bank b occupies addresses b*FRAME_WORDS .. b*FRAME_WORDS+FRAME_WORDS-1. Legal only if 2*FRAME_WORDS <= 2**ADDR_WIDTH and FRAME_WORDS >= 2.

Ports:
clk  in  1  single clock, shared with BRAM clkb.
reset  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request to stream a bank; honoured only when busy=0.
bank  in  1  bank select, sampled with accepted start.
abort  in  1  synchronous cancel of a running frame.
busy  out  1  frame in progress.
done  out  1  one-cycle pulse after last word handshake.
ram_ceb  out  1  BRAM read clock enable (one read per asserted cycle).
ram_adb  out  ADDR_WIDTH  BRAM read address.
ram_oce  out  1  tied 1 (bypass mode).
ram_dout  in  DATA_WIDTH  BRAM read data, valid the cycle after the ram_ceb cycle.
m_data  out  DATA_WIDTH  stream data (FIFO head).
m_valid  out  1  stream valid.
m_ready  in  1  stream ready.
m_last  out  1  marks word FRAME_WORDS-1 of the frame.

Behaviour:
- Reset (async): state IDLE; busy=0, done=0, ram_ceb=0, ram_adb=0, m_valid=0, m_last=0, m_data=0, FIFO empty, in-flight flag 0, counters 0. ram_oce=1 always.
- States: IDLE -> READ (on start & ~busy) -> DRAIN (after final read issued) -> DONE (one cycle) -> IDLE.
- Start accepted at edge E0: latch bank, issue counter=0, output counter=0, busy=1 from the next cycle. start while busy: ignored, no side effects.
- READ: issue read (ram_ceb=1, ram_adb=bank*FRAME_WORDS+issue_cnt) in a cycle iff fifo_count + inflight - pop < 2, where pop = m_valid & m_ready this cycle. ram_ceb=0 otherwise; ram_adb holds last value.
- inflight set the cycle after an issue; ram_dout written into FIFO at the end of that cycle; inflight cleared unless a new issue occurred.
- Latency: start cycle 0 -> first ram_ceb cycle 1 -> ram_dout valid cycle 2 -> m_valid cycle 3. Steady state with m_ready=1: one word per cycle, no bubbles.
- Issue of word FRAME_WORDS-1 moves READ -> DRAIN; no further reads.
- FIFO: 2 entries, first-word-fall-through; m_data/m_last stable while m_valid & ~m_ready. Never overflows (credit rule); simultaneous push and pop on a full-minus-one FIFO is legal.
- m_last=1 exactly on the FRAME_WORDS-th output word (output counter wraps only per frame).
- DRAIN -> DONE on handshake of the m_last word; DONE: done=1, busy=0, one cycle; then IDLE. A start in the DONE cycle is accepted (busy=0).
- abort (any non-IDLE state): next cycle IDLE, busy=0, FIFO flushed, m_valid=0, in-flight read data discarded, done not asserted. abort in IDLE: no effect. abort together with start in IDLE: abort wins, start dropped.
- Bank address arithmetic: base = bank ? FRAME_WORDS : 0, added to issue_cnt in ADDR_WIDTH bits; no wrap beyond bank end.
- Reset asserted mid-frame: immediate return to reset values; partial frame discarded.

Test Plan:
- m_ready=1, start bank=0 at cycle 0, BRAM preloaded addr=data -> m_valid cycles 3..258, m_data 0..255 in order, m_last only at cycle 258, done at cycle 259, busy 1 on cycles 1..258.
- bank=1, m_ready toggling 1/0 -> m_data 256..511 in order, no duplicates/drops, m_data stable during stalls, ram_ceb never issues a read that would overfill the 2-entry FIFO.
- m_ready=0 for 20 cycles after start -> exactly 2 reads issued (addr 0,1), m_valid=1 holding word 0; on release stream resumes with full rate.
- abort at cycle 50 with m_ready=1 -> cycle 51 busy=0, m_valid=0, no done; new start bank=0 then restarts at word 0.
- start pulsed at cycle 100 mid-frame -> ignored; start coinciding with done cycle -> second frame begins, first word m_valid 3 cycles later.
- async reset asserted mid-frame between clock edges -> all outputs zero immediately, FIFO empty after release.
